// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - fetch stage: PC, single-outstanding imem handshake, stall hold buffer, branch squash
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branchTaken,
    input  logic [31:0] branchTarget,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemReady,
    input  logic [31:0] imemData,
    output logic [31:0] instruction,
    output logic        noop,
    output logic [31:0] pcOut
);

    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_HOLD    = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_req_addr;
    logic [31:0] r_hold_data;
    logic [31:0] r_hold_pc;
    logic [31:0] r_instr;
    logic        r_noop;
    logic [31:0] r_pc_out;

    logic        w_req;
    logic        w_accept;
    logic [31:0] w_target;

    // Request is suppressed during the reset cycle so memory never sees a stale address.
    assign w_req    = reset && (r_state != S_HOLD);
    assign w_accept = w_req && imemReady;
    assign w_target = branchTarget & 32'hFFFF_FFFC;

    assign imemReq     = w_req;
    assign imemAddr    = (r_state == S_DISCARD) ? r_req_addr : r_pc;
    assign instruction = r_instr;
    assign noop        = r_noop;
    assign pcOut       = r_pc_out;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= S_FETCH;
            r_pc        <= RESET_PC;
            r_req_addr  <= 32'h0;
            r_hold_data <= 32'h0;
            r_hold_pc   <= 32'h0;
            r_instr     <= 32'h0;
            r_noop      <= 1'b1;
            r_pc_out    <= 32'h0;
        end else if (branchTaken) begin
            r_pc    <= w_target;
            r_instr <= 32'h0;
            r_noop  <= 1'b1;
            case (r_state)
                S_FETCH: begin
                    if (!imemReady) begin
                        r_req_addr <= r_pc;
                        r_state    <= S_DISCARD;
                    end
                end
                S_HOLD: begin
                    r_hold_data <= 32'h0;
                    r_hold_pc   <= 32'h0;
                    r_state     <= S_FETCH;
                end
                // A squashed request that completes this very cycle needs no further draining.
                S_DISCARD: begin
                    if (imemReady)
                        r_state <= S_FETCH;
                end
                default: r_state <= S_FETCH;
            endcase
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (w_accept) begin
                        r_pc <= r_pc + 32'd4;
                        if (stall) begin
                            r_hold_data <= imemData;
                            r_hold_pc   <= r_pc;
                            r_state     <= S_HOLD;
                        end else begin
                            r_instr  <= imemData;
                            r_noop   <= 1'b0;
                            r_pc_out <= r_pc;
                        end
                    end else if (!stall) begin
                        r_instr <= 32'h0;
                        r_noop  <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        r_instr  <= r_hold_data;
                        r_noop   <= 1'b0;
                        r_pc_out <= r_hold_pc;
                        r_state  <= S_FETCH;
                    end
                end
                S_DISCARD: begin
                    if (w_accept)
                        r_state <= S_FETCH;
                    if (!stall) begin
                        r_instr <= 32'h0;
                        r_noop  <= 1'b1;
                    end
                end
                default: r_state <= S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - randomized bench for instruction_fetch against a transaction-level model
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        br = 1'b0;
    logic [31:0] tgt = 32'h0;
    logic        rdy = 1'b0;
    logic [31:0] dat = 32'h0;
    logic        req;
    logic [31:0] addr;
    logic [31:0] instr;
    logic        noop;
    logic [31:0] pcout;

    logic        rst2 = 1'b0;
    logic        req2;
    logic [31:0] addr2;
    logic [31:0] dat2;
    logic [31:0] instr2;
    logic        noop2;
    logic [31:0] pcout2;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    instruction_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset(rst), .stall(stall), .branchTaken(br), .branchTarget(tgt),
        .imemReq(req), .imemAddr(addr), .imemReady(rdy), .imemData(dat),
        .instruction(instr), .noop(noop), .pcOut(pcout)
    );

    assign dat2 = word(addr2);

    instruction_fetch #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
        .clk(clk), .reset(rst2), .stall(1'b0), .branchTaken(1'b0), .branchTarget(32'h0),
        .imemReq(req2), .imemAddr(addr2), .imemReady(1'b1), .imemData(dat2),
        .instruction(instr2), .noop(noop2), .pcOut(pcout2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    endtask

    // Reference model: program counter, at most one parked word, optional squashed address.
    logic [31:0] m_pc = 32'h0;
    logic [63:0] m_held[$];
    bit          m_squash = 1'b0;
    logic [31:0] m_sq_addr = 32'h0;
    logic [31:0] m_instr = 32'h0;
    logic        m_noop = 1'b1;
    logic [31:0] m_pcout = 32'h0;

    function automatic logic [31:0] m_addr();
        return m_squash ? m_sq_addr : m_pc;
    endfunction

    task automatic model_step();
        bit fetched;
        fetched = (m_held.size() == 0) && rdy;
        if (!rst) begin
            m_pc = 32'h0; m_held.delete(); m_squash = 0;
            m_instr = 0; m_noop = 1; m_pcout = 0;
        end else if (br) begin
            m_instr = 0; m_noop = 1;
            if (m_held.size() != 0) m_held.delete();
            else if (m_squash) begin
                if (fetched) m_squash = 0;
            end else if (!fetched) begin
                m_squash = 1; m_sq_addr = m_pc;
            end
            m_pc = {tgt[31:2], 2'b00};
        end else if (m_held.size() != 0) begin
            if (!stall) begin
                m_instr = m_held[0][31:0]; m_pcout = m_held[0][63:32]; m_noop = 0;
                m_held.delete();
            end
        end else if (m_squash) begin
            if (fetched) m_squash = 0;
            if (!stall) begin m_instr = 0; m_noop = 1; end
        end else if (fetched) begin
            if (stall) m_held.push_back({m_pc, word(m_pc)});
            else begin m_instr = word(m_pc); m_pcout = m_pc; m_noop = 0; end
            m_pc = m_pc + 32'd4;
        end else if (!stall) begin
            m_instr = 0; m_noop = 1;
        end
    endtask

    task automatic cycle(input logic rs, input logic st, input logic b,
                         input logic [31:0] t, input logic rd);
        @(negedge clk);
        rst = rs; stall = st; br = b; tgt = t; rdy = rd;
        dat = word(m_addr());
        #1;
        if (rs) begin
            check("imemReq", {31'b0, req}, {31'b0, m_held.size() == 0});
            if (m_held.size() == 0) check("imemAddr", addr, m_addr());
        end else begin
            check("imemReq_in_reset", {31'b0, req}, 32'h0);
        end
        @(posedge clk);
        model_step();
        #1;
        check("instruction", instr, m_instr);
        check("noop", {31'b0, noop}, {31'b0, m_noop});
        check("pcOut", pcout, m_pcout);
    endtask

    initial begin
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 1);
        cycle(1, 0, 0, 0, 1);
        cycle(1, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 1);
        cycle(1, 1, 0, 0, 1);
        cycle(1, 1, 0, 0, 1);
        cycle(1, 0, 0, 0, 1);
        check("plan_addr_10", addr, 32'h10);
        for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0, 1);
        cycle(1, 0, 1, 32'h0000_0103, 0);
        cycle(1, 0, 0, 0, 0);
        check("plan_discard_addr", addr, 32'h20);
        cycle(1, 0, 0, 0, 1);
        check("plan_addr_100", addr, 32'h100);
        cycle(1, 1, 0, 0, 1);
        cycle(1, 1, 1, 32'h0000_0200, 1);
        check("plan_hold_branch_noop", {31'b0, noop}, 32'h1);
        cycle(1, 0, 0, 0, 1);
        cycle(1, 0, 1, 32'hFFFF_FFFE, 1);
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 1);

        for (int i = 0; i < 800; i++)
            cycle(($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1,
                  ($urandom_range(0, 99) < 30),
                  ($urandom_range(0, 99) < 8),
                  $urandom(),
                  ($urandom_range(0, 99) < 60));

        @(negedge clk); rst2 = 1'b0; #1;
        check("r2_req_in_reset", {31'b0, req2}, 32'h0);
        @(posedge clk); #1;
        check("r2_noop_reset", {31'b0, noop2}, 32'h1);
        check("r2_instr_reset", instr2, 32'h0);
        @(negedge clk); rst2 = 1'b1; #1;
        check("r2_addr0", addr2, 32'hFFFF_FFF8);
        @(negedge clk); #1;
        check("r2_addr1", addr2, 32'hFFFF_FFFC);
        check("r2_pcout1", pcout2, 32'hFFFF_FFF8);
        @(negedge clk); #1;
        check("r2_addr_wrap", addr2, 32'h0000_0000);
        check("r2_instr_fffc", instr2, word(32'hFFFF_FFFC));
        @(negedge clk); rst2 = 1'b0; #1;
        @(posedge clk); #1;
        check("r2_noop_midreset", {31'b0, noop2}, 32'h1);
        @(negedge clk); rst2 = 1'b1; #1;
        check("r2_addr_after_reset", addr2, 32'hFFFF_FFF8);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
